// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: edge filter, frame FSM, watchdog, error pulses, output FIFO.
// Define PS2_SCANCODE_DECODE_EN to fold E0/F0 prefixes into ext/break flags on each entry.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 5,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              ps2_clk,
  input  logic                              ps2_dat,
  input  logic                              out_ready,
  input  logic                              clear_err,
  output logic                              out_valid,
  output logic [7:0]                        out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              overflow
`ifdef PS2_SCANCODE_DECODE_EN
  ,
  output logic                              out_ext,
  output logic                              out_break
`endif
);
  localparam int FW = 2*FILTER_LEN;
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
`ifdef PS2_SCANCODE_DECODE_EN
  localparam int DW = 10;
`else
  localparam int DW = 8;
`endif

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt;
  logic          fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
      filt   <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      filt   <= {filt[FW-2:0], clk_s2};
    end
  end

  // Oldest half high, newest half low: a settled falling edge, seen for exactly one cycle.
  assign fall = (&filt[FW-1:FILTER_LEN]) && !(|filt[FILTER_LEN-1:0]);

  rx_state_e     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] wdog;
  logic          stop_fall, timeout, byte_ok, perr_evt, ferr_evt;
  logic          push, pop, full, empty;
  logic [DW-1:0] wr_data, rd_data;

  assign stop_fall = fall && (state == STOP);
  assign timeout   = (state != IDLE) && !fall && (wdog == TW'(TIMEOUT_CYCLES - 1));
  assign byte_ok   = stop_fall && dat_s2 && odd_parity_ok(shreg, par_bit);
  // A bad stop bit masks the parity check.
  assign perr_evt  = stop_fall && dat_s2 && !odd_parity_ok(shreg, par_bit);
  assign ferr_evt  = (stop_fall && !dat_s2) || timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      wdog       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= perr_evt;
      frame_err  <= ferr_evt;
      if (fall) begin
        wdog <= '0;
        case (state)
          IDLE: if (!dat_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        wdog <= '0;
      end else if (timeout) begin
        state <= IDLE;
        shreg <= '0;
        wdog  <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

`ifdef PS2_SCANCODE_DECODE_EN
  logic ext_f, brk_f;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (perr_evt || ferr_evt) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_ok) begin
      if (shreg == PS2_EXT_PREFIX)        ext_f <= 1'b1;
      else if (shreg == PS2_BREAK_PREFIX) brk_f <= 1'b1;
      else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  assign push      = byte_ok && (shreg != PS2_EXT_PREFIX) && (shreg != PS2_BREAK_PREFIX);
  assign wr_data   = {ext_f, brk_f, shreg};
  assign out_ext   = rd_data[9];
  assign out_break = rd_data[8];
`else
  assign push    = byte_ok;
  assign wr_data = shreg;
`endif

  assign out_data  = rd_data[7:0];
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      overflow <= 1'b0;
    else if (push && full && !pop)   overflow <= 1'b1;
    else if (clear_err)              overflow <= 1'b0;
  end

  sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level model with a queue, per-cycle compare, plus literal checks.
module tb_ps2_rx_fifo;
  localparam int F  = 5;
  localparam int D  = 8;
  localparam int T  = 600;
  localparam int H  = 20;
  localparam int CW = $clog2(D+1);
  localparam int LAT = 3 + F;   // pad edge -> registered effect: 2 sync flops, F filter samples, 1 register
  localparam int K_PUSH = 0, K_PERR = 1, K_FERR = 2;

  logic clock = 0, reset = 0, ps2_clk = 1, ps2_dat = 1, out_ready = 0, clear_err = 0;
  logic          out_valid, parity_err, frame_err, overflow;
  logic [7:0]    out_data;
  logic [CW-1:0] fifo_count;
`ifdef PS2_SCANCODE_DECODE_EN
  logic out_ext, out_break;
`endif

  ps2_rx_fifo #(.FILTER_LEN(F), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .out_ready(out_ready), .clear_err(clear_err), .out_valid(out_valid), .out_data(out_data),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
`ifdef PS2_SCANCODE_DECODE_EN
    , .out_ext(out_ext), .out_break(out_break)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int at; int kind; logic [9:0] val; } ev_t;

  int tests = 0, fails = 0, cyc = 0;
  ev_t evq[$];
  logic [9:0] q[$];
  bit m_ovf, exp_perr, exp_ferr, m_ext, m_brk, chk_en;
  ev_t pend;
  bit pend_v;
  int last_fall, last_ev_at;
  int n_vcyc, n_perr, n_ferr, seen_at;
  logic [7:0] seen_d;
  bit prev_v;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // Spec-level FIFO/flag model, advanced on every active edge.
  task automatic model_loop();
    ev_t e;
    bit pop, push, was_full;
    logic [9:0] v;
    forever begin
      @(posedge clock);
      cyc++;
      exp_perr = 0; exp_ferr = 0; push = 0; v = '0;
      if (!reset) begin
        q.delete();
        m_ovf = 0;
      end else begin
        while (evq.size() > 0 && evq[0].at <= cyc) begin
          e = evq.pop_front();
          if (e.kind == K_PUSH) begin push = 1; v = e.val; end
          else if (e.kind == K_PERR) exp_perr = 1;
          else exp_ferr = 1;
        end
        was_full = (q.size() == D);
        pop = out_ready && (q.size() > 0);
        if (push && was_full && !pop) m_ovf = 1;
        else if (clear_err) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (push && (!was_full || pop)) q.push_back(v);
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("out_valid", out_valid, q.size() != 0);
        chk("fifo_count", fifo_count, q.size());
        chk("overflow", overflow, m_ovf);
        chk("parity_err", parity_err, exp_perr);
        chk("frame_err", frame_err, exp_ferr);
        if (q.size() != 0) begin
          chk("out_data", out_data, q[0][7:0]);
`ifdef PS2_SCANCODE_DECODE_EN
          chk("out_ext", out_ext, q[0][9]);
          chk("out_break", out_break, q[0][8]);
`endif
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clock);
      if (out_valid) n_vcyc++;
      if (parity_err) n_perr++;
      if (frame_err) n_ferr++;
      if (out_valid && !prev_v) begin seen_d = out_data; seen_at = cyc; end
      prev_v = out_valid;
    end
  endtask

  task automatic send_bit(bit b, bit glitch);
    ps2_dat = b;
    if (glitch) begin
      tick(5); ps2_clk = 0; tick(F-1); ps2_clk = 1; tick(H-5-(F-1));
    end else tick(H);
    ps2_clk = 0;
    last_fall = cyc + LAT;
    if (pend_v) begin
      pend.at = last_fall; last_ev_at = last_fall;
      evq.push_back(pend); pend_v = 0;
    end
    tick(H);
    ps2_clk = 1;
  endtask

  // Frame outcome from the protocol rules alone; attached to the stop-bit edge.
  task automatic model_frame(logic [7:0] d, bit p, bit s);
    pend_v = 1; pend.val = '0;
    if (!s) begin pend.kind = K_FERR; m_ext = 0; m_brk = 0; end
    else if (^{d, p} == 1'b0) begin pend.kind = K_PERR; m_ext = 0; m_brk = 0; end
    else begin
      pend.kind = K_PUSH;
`ifdef PS2_SCANCODE_DECODE_EN
      if (d == 8'hE0) begin m_ext = 1; pend_v = 0; end
      else if (d == 8'hF0) begin m_brk = 1; pend_v = 0; end
      else begin pend.val = {m_ext, m_brk, d}; m_ext = 0; m_brk = 0; end
`else
      pend.val = {2'b00, d};
`endif
    end
  endtask

  task automatic send_frame(logic [7:0] d, bit p, bit s, int g);
    send_bit(1'b0, g == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], g == i+1);
    send_bit(p, g == 9);
    model_frame(d, p, s);
    send_bit(s, 1'b0);
    tick(H);
  endtask

  task automatic send_partial(logic [7:0] d, int n);
    ev_t e;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], 1'b0);
    e.at = last_fall + T; e.kind = K_FERR; e.val = '0;
    evq.push_back(e); m_ext = 0; m_brk = 0;
    tick(T + 40);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL sim_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int bp, bf, bv;
    logic [7:0] b;
    fork
      model_loop();
      compare_loop();
      monitor_loop();
    join_none
    tick(4);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1; tick(2); chk_en = 1; tick(H);

    // single byte, consumer always ready
    out_ready = 1; bv = n_vcyc;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("single_data", seen_d, 8'h1C);
    chk("single_latency", seen_at, last_ev_at);
    chk("single_vcycles", n_vcyc - bv, 1);
    chk("single_drained", fifo_count, 0);

    // parity error, then recovery
    bp = n_perr;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    chk("perr_pulses", n_perr - bp, 1);
    chk("perr_count", fifo_count, 0);
    send_frame(8'h32, 1'b0, 1'b1, -1);
    chk("after_perr_data", seen_d, 8'h32);

    // stop error, watchdog timeout, recovery
    bf = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    chk("stop_err_pulses", n_ferr - bf, 1);
    send_partial(8'h0F, 4);
    chk("timeout_pulses", n_ferr - bf, 2);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    chk("after_timeout_data", seen_d, 8'h5A);

    // glitches: short low pulse in IDLE with data low, a real edge with data high, mid-frame glitch
    bp = n_perr; bf = n_ferr;
    ps2_dat = 0; ps2_clk = 0; tick(F-1); ps2_clk = 1; tick(H);
    ps2_dat = 1; tick(H); ps2_clk = 0; tick(H); ps2_clk = 1; tick(H);
    send_frame(8'h6B, 1'b0, 1'b1, 5);
    chk("glitch_data", seen_d, 8'h6B);
    chk("glitch_no_err", (n_perr - bp) + (n_ferr - bf), 0);

    // overflow: FIFO_DEPTH+1 bytes with no consumer
    out_ready = 0;
    for (int i = 0; i < D+1; i++) begin
      b = 8'h10 + 8'(i);
      send_frame(b, ~^b, 1'b1, -1);
    end
    chk("ovf_count", fifo_count, D);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < D; i++) begin
      chk("drain_order", out_data, 8'h10 + 8'(i));
      out_ready = 1; tick(1); out_ready = 0;
    end
    chk("drain_empty", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);
    clear_err = 1; tick(1); clear_err = 0;
    chk("ovf_cleared", overflow, 0);

    // scancode prefixes
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
`ifdef PS2_SCANCODE_DECODE_EN
    chk("dec_count", fifo_count, 1);
    chk("dec_data", out_data, 8'h75);
    chk("dec_ext", out_ext, 1);
    chk("dec_brk", out_break, 1);
    out_ready = 1; tick(1); out_ready = 0;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("dec2_data", out_data, 8'h1C);
    chk("dec2_ext", out_ext, 0);
    chk("dec2_brk", out_break, 0);
`else
    chk("raw_count", fifo_count, 3);
    chk("raw_head", out_data, 8'hE0);
`endif
    out_ready = 1; tick(5); out_ready = 0;

    // reset mid-frame with a byte waiting
    send_frame(8'h21, 1'b1, 1'b1, -1);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    chk_en = 0; reset = 0;
    evq.delete(); pend_v = 0; m_ext = 0; m_brk = 0;
    tick(3);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", out_valid, 0);
    reset = 1; tick(2); chk_en = 1; tick(H);
    out_ready = 1;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("after_rst_data", seen_d, 8'h1C);
    tick(H);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
